// File: rtl/gumnut_pkg.sv
// Shared constants and types for the Gumnut core.
package gumnut_pkg;

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned INSTR_W = 18;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StHold
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch unit: runs one Wishbone-style read per fetch and holds the result for decode.
module inst_fetch
  import gumnut_pkg::*;
(
  input  logic               clkg,
  input  logic               rst,
  input  logic               fetch_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic               flush_i,
  output logic               inst_cyc_o,
  output logic               inst_stb_o,
  output logic [ADDR_W-1:0]  inst_adr_o,
  input  logic               inst_ack_i,
  input  logic [INSTR_W-1:0] inst_dat_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic               pc_we_o,
  output logic [ADDR_W-1:0]  pc_next_o,
  output logic               busy_o
);

  localparam logic [ADDR_W-1:0] PcInc = {{(ADDR_W-1){1'b0}}, 1'b1};

  fetch_state_t       state_q, state_d;
  logic               discard_q, discard_d;
  logic [ADDR_W-1:0]  adr_q, adr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               pc_we_q, pc_we_d;
  logic [ADDR_W-1:0]  pc_next_q, pc_next_d;

  always_comb begin
    state_d    = state_q;
    discard_d  = discard_q;
    adr_d      = adr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    pc_we_d    = 1'b0;
    pc_next_d  = pc_next_q;

    unique case (state_q)
      StIdle: begin
        if (fetch_i) begin
          adr_d   = pc_i;
          state_d = StReq;
        end
      end
      StReq: begin
        // The bus cycle always runs to ack; a flush only poisons the returning data.
        if (inst_ack_i) begin
          if (discard_q || flush_i) begin
            discard_d = 1'b0;
            state_d   = StIdle;
          end else begin
            instr_d    = inst_dat_i;
            instr_pc_d = adr_q;
            state_d    = StHold;
          end
        end else if (flush_i) begin
          discard_d = 1'b1;
        end
      end
      StHold: begin
        if (flush_i || instr_ready_i) begin
          // Flush beats a same-cycle accept: no PC write.
          if (!flush_i) begin
            pc_we_d   = 1'b1;
            pc_next_d = instr_pc_q + PcInc;
          end
          if (fetch_i) begin
            adr_d   = pc_i;
            state_d = StReq;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clkg or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      discard_q  <= 1'b0;
      adr_q      <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      pc_we_q    <= 1'b0;
      pc_next_q  <= '0;
    end else begin
      state_q    <= state_d;
      discard_q  <= discard_d;
      adr_q      <= adr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      pc_we_q    <= pc_we_d;
      pc_next_q  <= pc_next_d;
    end
  end

  assign inst_cyc_o    = (state_q == StReq);
  assign inst_stb_o    = (state_q == StReq);
  assign inst_adr_o    = adr_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign instr_valid_o = (state_q == StHold);
  assign pc_we_o       = pc_we_q;
  assign pc_next_o     = pc_next_q;
  assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a transaction-level reference model checked every cycle.
module tb_inst_fetch;

  logic        clkg = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_i = 1'b0;
  logic [11:0] pc_i = '0;
  logic        flush_i = 1'b0;
  logic        inst_cyc_o, inst_stb_o;
  logic [11:0] inst_adr_o;
  logic        inst_ack_i = 1'b0;
  logic [17:0] inst_dat_i = '0;
  logic [17:0] instr_o;
  logic [11:0] instr_pc_o;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic        pc_we_o;
  logic [11:0] pc_next_o;
  logic        busy_o;

  int vectors = 0;
  int errors  = 0;

  always #5 clkg = ~clkg;

  inst_fetch dut (
    .clkg         (clkg),
    .rst          (rst),
    .fetch_i      (fetch_i),
    .pc_i         (pc_i),
    .flush_i      (flush_i),
    .inst_cyc_o   (inst_cyc_o),
    .inst_stb_o   (inst_stb_o),
    .inst_adr_o   (inst_adr_o),
    .inst_ack_i   (inst_ack_i),
    .inst_dat_i   (inst_dat_i),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .pc_we_o      (pc_we_o),
    .pc_next_o    (pc_next_o),
    .busy_o       (busy_o)
  );

  // Instruction memory contents; address 0x010 holds 0x2A5F3.
  function automatic logic [17:0] mem(input logic [11:0] a);
    return 18'h2A5F3 ^ {6'd0, a ^ 12'h010};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an open bus transaction, a held instruction, and a poisoned-return flag.
  logic        m_bus, m_have, m_drop, m_we;
  logic [11:0] m_adr, m_ipc, m_next;
  logic [17:0] m_instr;

  always @(posedge clkg or posedge rst) begin
    if (rst) begin
      m_bus <= 1'b0; m_have <= 1'b0; m_drop <= 1'b0; m_we <= 1'b0;
      m_adr <= '0; m_ipc <= '0; m_next <= '0; m_instr <= '0;
    end else begin
      m_we <= 1'b0;
      if (m_bus) begin
        if (inst_ack_i) begin
          m_bus <= 1'b0;
          if (m_drop || flush_i) m_drop <= 1'b0;
          else begin
            m_have  <= 1'b1;
            m_instr <= mem(m_adr);
            m_ipc   <= m_adr;
          end
        end else if (flush_i) m_drop <= 1'b1;
      end else if (m_have) begin
        if (!flush_i && instr_ready_i) begin
          m_we   <= 1'b1;
          m_next <= m_ipc + 12'd1;
        end
        if (flush_i || instr_ready_i) begin
          m_have <= 1'b0;
          if (fetch_i) begin
            m_bus <= 1'b1;
            m_adr <= pc_i;
          end
        end
      end else if (fetch_i) begin
        m_bus <= 1'b1;
        m_adr <= pc_i;
      end
    end
  end

  // Memory side of the bus: data follows the address the DUT presents.
  always_comb inst_dat_i = mem(inst_adr_o);

  always @(negedge clkg) begin
    if (!rst) begin
      check("cyc", 32'(inst_cyc_o), 32'(m_bus));
      check("stb", 32'(inst_stb_o), 32'(m_bus));
      check("valid", 32'(instr_valid_o), 32'(m_have));
      check("busy", 32'(busy_o), 32'(m_bus | m_have));
      check("pc_we", 32'(pc_we_o), 32'(m_we));
      if (m_bus) check("adr", 32'(inst_adr_o), 32'(m_adr));
      if (m_have) begin
        check("instr", 32'(instr_o), 32'(m_instr));
        check("instr_pc", 32'(instr_pc_o), 32'(m_ipc));
      end
      if (m_we) check("pc_next", 32'(pc_next_o), 32'(m_next));
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clkg);
      #1;
    end
  endtask

  // Fetch with the given wait states; leaves the unit in HOLD.
  task automatic do_fetch(input logic [11:0] a, input int waits);
    fetch_i = 1'b1; pc_i = a;
    tick();
    fetch_i = 1'b0;
    tick(waits);
    inst_ack_i = 1'b1;
    tick();
    inst_ack_i = 1'b0;
  endtask

  task automatic accept();
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
  endtask

  initial begin
    tick(2);
    check("rst_cyc", 32'(inst_cyc_o), 32'd0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_instr", 32'(instr_o), 32'd0);
    check("rst_pc_next", 32'(pc_next_o), 32'd0);
    rst = 1'b0;
    tick();

    // Zero-wait fetch at 0x010.
    fetch_i = 1'b1; pc_i = 12'h010;
    tick();
    fetch_i = 1'b0;
    check("t1_cyc", 32'(inst_cyc_o), 32'd1);
    check("t1_adr", 32'(inst_adr_o), 32'h010);
    inst_ack_i = 1'b1;
    tick();
    inst_ack_i = 1'b0;
    check("t1_valid", 32'(instr_valid_o), 32'd1);
    check("t1_instr", 32'(instr_o), 32'h2A5F3);
    check("t1_instr_pc", 32'(instr_pc_o), 32'h010);
    accept();
    check("t1_we", 32'(pc_we_o), 32'd1);
    check("t1_next", 32'(pc_next_o), 32'h011);
    check("t1_valid_drop", 32'(instr_valid_o), 32'd0);
    tick();
    check("t1_we_once", 32'(pc_we_o), 32'd0);

    // Three wait states, then four cycles of backpressure.
    do_fetch(12'h123, 3);
    tick(4);
    check("t2_held", 32'(instr_o), 32'(18'h2A5F3 ^ 18'h133));
    accept();
    check("t2_next", 32'(pc_next_o), 32'h124);
    tick();

    // Address wrap.
    do_fetch(12'hFFF, 0);
    accept();
    check("t3_we", 32'(pc_we_o), 32'd1);
    check("t3_wrap", 32'(pc_next_o), 32'h000);
    tick();

    // Flush during REQ, ack two cycles later.
    fetch_i = 1'b1; pc_i = 12'h050;
    tick();
    fetch_i = 1'b0; flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    tick();
    check("t4_cyc_open", 32'(inst_cyc_o), 32'd1);
    inst_ack_i = 1'b1;
    tick();
    inst_ack_i = 1'b0;
    check("t4_busy", 32'(busy_o), 32'd0);
    check("t4_valid", 32'(instr_valid_o), 32'd0);
    tick();
    do_fetch(12'h100, 0);
    check("t4_refetch", 32'(instr_o), 32'h2A4E3);
    accept();
    tick();

    // Flush coinciding with ack.
    fetch_i = 1'b1; pc_i = 12'h060;
    tick();
    fetch_i = 1'b0; flush_i = 1'b1; inst_ack_i = 1'b1;
    tick();
    flush_i = 1'b0; inst_ack_i = 1'b0;
    check("t4b_valid", 32'(instr_valid_o), 32'd0);
    check("t4b_busy", 32'(busy_o), 32'd0);
    tick();

    // Flush, accept and refetch together in HOLD.
    do_fetch(12'h300, 0);
    flush_i = 1'b1; instr_ready_i = 1'b1; fetch_i = 1'b1; pc_i = 12'h200;
    tick();
    flush_i = 1'b0; instr_ready_i = 1'b0; fetch_i = 1'b0;
    check("t5_no_we", 32'(pc_we_o), 32'd0);
    check("t5_valid", 32'(instr_valid_o), 32'd0);
    check("t5_cyc", 32'(inst_cyc_o), 32'd1);
    check("t5_adr", 32'(inst_adr_o), 32'h200);
    inst_ack_i = 1'b1;
    tick();
    inst_ack_i = 1'b0;
    accept();
    check("t5_next", 32'(pc_next_o), 32'h201);
    tick();

    // Back-to-back: accept and refetch in the same cycle.
    do_fetch(12'h020, 0);
    instr_ready_i = 1'b1; fetch_i = 1'b1; pc_i = 12'h021;
    tick();
    instr_ready_i = 1'b0; fetch_i = 1'b0;
    check("t6_we", 32'(pc_we_o), 32'd1);
    check("t6_cyc", 32'(inst_cyc_o), 32'd1);
    inst_ack_i = 1'b1;
    tick();
    inst_ack_i = 1'b0;
    accept();
    tick();

    // Asynchronous reset mid-REQ, then a stray ack.
    fetch_i = 1'b1; pc_i = 12'h400;
    tick();
    fetch_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t7_cyc", 32'(inst_cyc_o), 32'd0);
    check("t7_stb", 32'(inst_stb_o), 32'd0);
    check("t7_valid", 32'(instr_valid_o), 32'd0);
    check("t7_busy", 32'(busy_o), 32'd0);
    tick();
    rst = 1'b0;
    inst_ack_i = 1'b1;
    tick();
    inst_ack_i = 1'b0;
    check("t7_stray_ack", 32'(instr_valid_o), 32'd0);
    check("t7_idle", 32'(busy_o), 32'd0);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit for the Gumnut core: the consumer side of the program counter. Takes the current PC, runs a Wishbone-style read cycle on the instruction memory port, and presents the fetched 18-bit instruction to decode over a valid/ready handshake. On acceptance it drives the PC write strobe and next-sequential address back into the program counter. Sits between the program counter, instruction memory and the decode/control FSM.

## Interface

- ADDR_W, 12, instruction address width (PC width)
- INSTR_W, 18, instruction word width
- clkg  input  1  gated core clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- fetch_i  input  1  control requests a fetch at pc_i
- pc_i  input  ADDR_W  address to fetch (program counter output)
- flush_i  input  1  discard in-flight/held instruction (taken branch, jump, ret, interrupt)
- inst_cyc_o  output  1  bus cycle active
- inst_stb_o  output  1  bus strobe
- inst_adr_o  output  ADDR_W  bus address
- inst_ack_i  input  1  memory acknowledge; data valid this cycle
- inst_dat_i  input  INSTR_W  memory read data
- instr_o  output  INSTR_W  held instruction
- instr_pc_o  output  ADDR_W  address instr_o was fetched from
- instr_valid_o  output  1  instr_o valid
- instr_ready_i  input  1  decode accepts instr_o
- pc_we_o  output  1  one-cycle write strobe to program counter
- pc_next_o  output  ADDR_W  instr_pc_o + 1, modulo 2^ADDR_W
- busy_o  output  1  state ≠ IDLE

## Operation

- States: IDLE, REQ, HOLD. Reset → IDLE; all outputs 0 (inst_adr_o, instr_o, instr_pc_o, pc_next_o = 0).
- IDLE: fetch_i=1 → register pc_i into inst_adr_o, assert cyc/stb, → REQ. flush_i ignored.
- REQ: cyc/stb held, inst_adr_o stable until ack. fetch_i ignored. On inst_ack_i=1: drop cyc/stb; if discard flag clear, latch inst_dat_i→instr_o, inst_adr_o→instr_pc_o, → HOLD; if set, clear flag, → IDLE, data dropped.
- flush_i in REQ: set discard flag; bus cycle is never aborted, always completes on ack. flush_i with ack in the same cycle: discard that data.
- HOLD: instr_valid_o=1; instr_o/instr_pc_o stable. Transfer = instr_valid_o & instr_ready_i at the edge → pc_we_o=1 for the next cycle with pc_next_o = instr_pc_o+1 (0xFFF wraps to 0x000); then fetch_i=1 → REQ at pc_i (back-to-back), else IDLE.
- flush_i in HOLD: valid drops next cycle, no pc_we_o, even if instr_ready_i=1 the same cycle (flush wins). With fetch_i=1 same cycle → REQ at pc_i; else IDLE.
- rst mid-cycle: cyc/stb/valid/pc_we drop immediately (async); discard flag cleared; a later stray ack in IDLE is ignored.
- inst_ack_i outside REQ: ignored.

## Timing

- All outputs registered; no combinational input→output path.
- fetch_i high at edge n (IDLE) → cyc/stb/adr valid after edge n. Zero-wait memory (ack sampled at edge n+1) → instr_valid_o high after edge n+1: fetch-to-valid latency 2 cycles; each wait state adds 1.
- Accept at edge k → pc_we_o high exactly one cycle after edge k; instr_valid_o low after k unless back-to-back refetch.
- Back-to-back sustained rate: one instruction per 2 cycles with zero-wait memory.
- cyc and stb always identical; never asserted outside REQ.

## Structure

- Shared package gumnut_pkg: ADDR_W, INSTR_W constants; fetch_state_t enum (IDLE, REQ, HOLD).
- Single flat module; FSM, discard flag and output registers only. No sub-module is natural.

## Test plan

- Zero-wait fetch: fetch_i with pc_i=0x010, ack next cycle with dat=0x2A5F3 → instr_valid_o 2 cycles after fetch, instr_o=0x2A5F3, instr_pc_o=0x010; ready=1 → pc_we_o one cycle, pc_next_o=0x011.
- Wait states + backpressure: ack after 3 wait cycles, ready held low 4 cycles → cyc/stb/adr stable throughout REQ, instr_o stable throughout HOLD, single pc_we_o on acceptance.
- Wrap: pc_i=0xFFF fetched and accepted → pc_next_o=0x000.
- Flush in REQ: flush_i 1 cycle after fetch, ack 2 cycles later → bus cycle completes, no instr_valid_o, no pc_we_o, busy_o low after ack; next fetch at 0x100 returns correct data.
- Flush vs accept in HOLD: flush_i, instr_ready_i, fetch_i all high with pc_i=0x200 → no pc_we_o, valid drops, new REQ at adr 0x200.
- Async reset during REQ with ack pending → cyc/stb/valid low immediately, state IDLE; ack pulse after reset produces no valid.
